// File: rtl/direction_input_ctrl.sv
// Button front-end for the 2048 game FSM: sync, debounce, press detect and a one-request-per-press
// handshake onto the one-hot direction bus. Define AUTO_REPEAT_EN to reissue a held direction.
module direction_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  input  logic       ready,
  output logic [3:0] direction,
  output logic [3:0] btn_level
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      $clog2(DEBOUNCE_CYCLES) > CNT_W || $clog2(REPEAT_CYCLES) > CNT_W) begin : g_bad_cfg
    $error("direction_input_ctrl: invalid DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       s;
  logic [CNT_W-1:0] db_cnt [4];
  logic [3:0]       commit;
  logic [3:0]       press;

  state_t     state;
  state_t     state_nx;
  logic [3:0] dir_nx;

  // Synchronizers reset to "released" so a held button after reset is seen as a fresh press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  always_comb begin
    commit = '0;
    for (int i = 0; i < 4; i++) begin
      commit[i] = (s[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // Only a 0->1 commit is a press; release commits never raise a request.
  assign press = commit & s;

  // NOTE: db_cnt is a handful of flops, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (commit[i]) begin
          btn_level[i] <= s[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nx;
  logic [3:0]       last_dir;
  logic [3:0]       last_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt  <= '0;
      last_dir <= '0;
    end else begin
      rep_cnt  <= rep_nx;
      last_dir <= last_nx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      direction <= '0;
    end else begin
      state     <= state_nx;
      direction <= dir_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    dir_nx   = direction;
`ifdef AUTO_REPEAT_EN
    rep_nx   = rep_cnt;
    last_nx  = last_dir;
`endif
    case (state)
      IDLE: begin
        if (press != 4'b0000) begin
          // Isolate lowest set bit: up wins over down over left over right.
          dir_nx   = press & (~press + 4'd1);
          state_nx = PENDING;
        end
      end
      PENDING: begin
        if (ready && direction != 4'b0000) begin
          dir_nx   = '0;
          state_nx = WAIT_RELEASE;
`ifdef AUTO_REPEAT_EN
          rep_nx   = '0;
          last_nx  = direction;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (btn_level == 4'b0000) begin
          state_nx = IDLE;
`ifdef AUTO_REPEAT_EN
        end else if (btn_level == last_dir) begin
          if (rep_cnt == REP_LAST) begin
            dir_nx   = last_dir;
            rep_nx   = '0;
            state_nx = PENDING;
          end else begin
            rep_nx = rep_cnt + CNT_W'(1);
          end
        end else begin
          rep_nx = '0;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        dir_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// A per-cycle vector table covers the main flows; hand sequences cover reset and hold/repeat.
module tb_direction_input_ctrl;

  localparam int DB  = 4;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic       ready;
  logic [3:0] direction;
  logic [3:0] btn_level;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] btn_n;
    logic       ready;
    logic [3:0] exp_dir;
    logic [3:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  direction_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (REP),
    .CNT_W          (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .ready    (ready),
    .direction(direction),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic r, input logic [3:0] d,
                     input logic [3:0] l, input int n);
    vec_t v;
    v.btn_n = b; v.ready = r; v.exp_dir = d; v.exp_lvl = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive at the falling edge, clock once, sample at the next falling edge.
  task automatic step(input logic [3:0] b, input logic r);
    btn_n = b;
    ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_d;
    rst   = 1'b1;
    btn_n = 4'b1111;
    ready = 1'b0;

    // Left press with ready: one pulse after edge 6, then silent while held and on release.
    add(4'b1011, 1, 4'b0000, 4'b0000, 5);
    add(4'b1011, 1, 4'b0100, 4'b0100, 1);
    add(4'b1011, 1, 4'b0000, 4'b0100, 2);
    add(4'b1111, 1, 4'b0000, 4'b0100, 5);
    add(4'b1111, 1, 4'b0000, 4'b0000, 3);
    // Up button chattering every 2 cycles never commits.
    for (int k = 0; k < 5; k++) begin
      add(4'b1110, 1, 4'b0000, 4'b0000, 2);
      add(4'b1111, 1, 4'b0000, 4'b0000, 2);
    end
    add(4'b1111, 1, 4'b0000, 4'b0000, 4);
    // Down+right together, ready low: down wins and is held; right never follows.
    add(4'b0101, 0, 4'b0000, 4'b0000, 5);
    add(4'b0101, 0, 4'b0010, 4'b1010, 11);
    add(4'b0101, 1, 4'b0000, 4'b1010, 6);
    add(4'b1111, 1, 4'b0000, 4'b1010, 5);
    add(4'b1111, 1, 4'b0000, 4'b0000, 3);
    // Second right press gives its own request; bouncy release gives none.
    add(4'b0111, 1, 4'b0000, 4'b0000, 5);
    add(4'b0111, 1, 4'b1000, 4'b1000, 1);
    add(4'b1111, 1, 4'b0000, 4'b1000, 1);
    add(4'b0111, 1, 4'b0000, 4'b1000, 1);
    add(4'b1111, 1, 4'b0000, 4'b1000, 5);
    add(4'b1111, 1, 4'b0000, 4'b0000, 3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dir", direction, 4'b0000);
    check("reset_lvl", btn_level, 4'b0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].btn_n, vecs[i].ready);
      check($sformatf("vec%0d_dir", i), direction, vecs[i].exp_dir);
      check($sformatf("vec%0d_lvl", i), btn_level, vecs[i].exp_lvl);
    end

    // Reset while a request is pending: it is dropped, and the held button re-requests.
    for (int e = 1; e <= 7; e++) begin
      step(4'b1110, 0);
      if (e == 6 || e == 7) check($sformatf("pend_e%0d", e), direction, 4'b0001);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_dir", direction, 4'b0000);
    check("midrst_lvl", btn_level, 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= DB + 2; e++) begin
      step(4'b1110, 0);
      exp_d = (e == DB + 2) ? 4'b0001 : 4'b0000;
      check($sformatf("postrst_e%0d_dir", e), direction, exp_d);
      check($sformatf("postrst_e%0d_lvl", e), btn_level, exp_d);
    end
    step(4'b1111, 1);
    check("postrst_xfer", direction, 4'b0000);
    repeat (7) step(4'b1111, 1);
    check("postrst_rel_dir", direction, 4'b0000);
    check("postrst_rel_lvl", btn_level, 4'b0000);

    // Up held with ready: a single pulse, or a pulse every REP+1 cycles with auto-repeat.
    for (int e = 1; e <= 25; e++) begin
      step(4'b1110, 1);
      exp_d = (e == DB + 2) ? 4'b0001 : 4'b0000;
`ifdef AUTO_REPEAT_EN
      if (e == DB + 2 + (REP + 1) || e == DB + 2 + 2 * (REP + 1)) exp_d = 4'b0001;
`endif
      check($sformatf("hold_e%0d", e), direction, exp_d);
    end
    for (int e = 1; e <= 8; e++) begin
      step(4'b1111, 1);
      check($sformatf("hold_rel_e%0d", e), direction, 4'b0000);
    end
    check("hold_rel_lvl", btn_level, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
